serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing diff = a - b - bin, one bit per clock, LSB first.
It is the subtract-direction counterpart of the team's adder cells and reuses one full-subtractor cell with a registered borrow.
It sits in the arithmetic_op library as the area-cheap subtract path for multi-cycle datapaths, using a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when ready=1
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
ready  output  1  high in IDLE and DONE; start is accepted only when high
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  difference; held stable from done until the next accepted start
bout  output  1  borrow out of MSB; 1 means unsigned a < b + bin
ovf  output  1  signed overflow flag

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high. Every register updates on the rising edge of clk only.
- Reset: state=IDLE; diff=0, bout=0, ovf=0, done=0, busy=0, ready=1; internal shift registers, bit counter and borrow register cleared.
- Reset mid-operation: abandons the operation, takes the reset values above on the next edge, and produces no done pulse.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> DONE after WIDTH bit-steps.
  - DONE -> RUN on start (back-to-back operation); otherwise DONE -> IDLE.
- Accept (edge k, start=1, ready=1):
  - load a_sh=a, b_sh=b, borrow=bin, cnt=0;
  - clear diff, bout and ovf;
  - busy rises in the next cycle.
- RUN, each edge:
  - the full_subtractor cell computes d=a_sh[0]^b_sh[0]^borrow and bo=(~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow);
  - d shifts into the result MSB with the result register shifting right; a_sh and b_sh shift right;
  - borrow<=bo; cnt<=cnt+1.
- Last bit (cnt==WIDTH-1):
  - ovf <= borrow_in_to_msb ^ bo;
  - bout <= bo;
  - state -> DONE; done=1 in the following cycle.
- Latency: done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from the start edge. busy is high for exactly WIDTH cycles.
- start while busy: ignored, with no effect on the in-flight operation. Operand changes while busy are also ignored.
- start in the DONE cycle: accepted; done is still pulsed for the finishing operation, and diff, bout and ovf clear on that same edge.
- cnt width is clog2(WIDTH)+1. There is no wrap-around, because RUN exits when cnt==WIDTH-1.

Decomposition:
- Shared header arith_defs.vh holds:
  - the FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2 (2'd3 is illegal and recovers to IDLE);
  - the clog2 constant function.
- Sub-module full_subtractor (a, b, bin -> diff, bout), built from two half_subtractor cells plus an OR on the borrows. It mirrors the adder cell structure and has its own unit test.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, bin=0, start one cycle -> done exactly 9 cycles later; diff=0x23, bout=0, ovf=0; busy high for 8 cycles.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0.
- a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- Handshake ordering:
  - start with a=0x55, b=0x11 is accepted;
  - start with a=0xAA is pulsed at RUN cycle 3 -> it is ignored and the result is 0x44;
  - start with a=0x09, b=0x03 is held in the DONE cycle -> it is accepted back-to-back, and the next result is 0x06.
- Assert rst at RUN cycle 4 -> the next cycle shows IDLE, diff=0, no done pulse. A following operation 0x35-0x12 still yields 0x23.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// a constant clog2 used to size the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit subtract cells: full_subtractor is two half_subtractor stages
// with the stage borrows ORed, mirroring the adder cell structure.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);
    assign d = x ^ y;
    assign b = ~x & y;
endmodule

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (.x(a),  .y(b),   .d(d1),   .b(b1));
    half_subtractor u_hs1 (.x(d1), .y(bin), .d(diff), .b(b2));

    assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, diff = a - b - bin, LSB first,
// one full_subtractor step per clock with a start/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int unsigned CW = clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bo;
    logic             last;

    full_subtractor u_fs (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (borrow),
        .diff(d),
        .bout(bo)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        diff   <= '0;
                        bout   <= 1'b0;
                        ovf    <= 1'b0;
                        state  <= ST_RUN;
                        busy   <= 1'b1;
                        ready  <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    diff   <= {d, diff[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    borrow <= bo;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        // borrow here is the carry into the MSB step
                        ovf   <= borrow ^ bo;
                        bout  <= bo;
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
